gtech_reduce_pipe: RTL and testbench

Parametrised successor to the fixed 3-input NOR primitive.
- Performs a bitwise logic reduction of N operands, each W bits wide, with the operation selected per transaction (AND/OR/XOR/NAND/NOR/XNOR).
- The result passes through a valid/ready register pipeline STAGES deep.
- Sits in the GTECH library as a generic registered reduction cell for synthesis mapping and for datapath glue.

---
 rtl/gtech_reduce_pkg.sv | 59 +++++
 rtl/gtech_pipe_stage.sv | 28 ++
 rtl/gtech_reduce_pipe.sv | 90 +++++++++
 tb/tb_gtech_reduce_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gtech_reduce_pkg.sv
// gtech_reduce_pkg: shared constants, mode encodings and the bitwise
// reduction function used by the gtech_reduce_pipe cell.
package gtech_reduce_pkg;

    localparam int MODE_W  = 3;

    // Upper bounds for the generic reduce() function; the pipe checks its
    // own N and W against these at elaboration.
    localparam int MAX_N   = 64;
    localparam int MAX_W   = 64;
    localparam int MAX_VEC = MAX_N * MAX_W;

    typedef enum logic [MODE_W-1:0] {
        MODE_AND  = 3'd0,
        MODE_OR   = 3'd1,
        MODE_XOR  = 3'd2,
        MODE_NAND = 3'd3,
        MODE_NOR  = 3'd4,
        MODE_XNOR = 3'd5
    } mode_e;

    // Reduce n operands of w bits each (operand i at ops[i*w +: w]) bit by bit.
    // Unused high result bits are forced to 0. Reserved modes act as NOR.
    function automatic logic [MAX_W-1:0] reduce(
        input logic [MODE_W-1:0]  mode,
        input logic [MAX_VEC-1:0] ops,
        input int                 n,
        input int                 w
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] opnd;
        logic [MAX_W-1:0] all_and;
        logic [MAX_W-1:0] any_or;
        logic [MAX_W-1:0] parity;
        logic [MAX_W-1:0] res;
        mask    = (w >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << w) - MAX_W'(1));
        all_and = {MAX_W{1'b1}};
        any_or  = '0;
        parity  = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                opnd    = MAX_W'(ops >> (i * w)) & mask;
                all_and = all_and & opnd;
                any_or  = any_or | opnd;
                parity  = parity ^ opnd;
            end
        end
        case (mode)
            MODE_AND:  res = all_and;
            MODE_OR:   res = any_or;
            MODE_XOR:  res = parity;
            MODE_NAND: res = ~all_and;
            MODE_XNOR: res = ~parity;
            default:   res = ~any_or;
        endcase
        return res & mask;
    endfunction

endpackage

// File: rtl/gtech_pipe_stage.sv
// gtech_pipe_stage: one valid/ready register slice of the reduction pipe.
// The stage loads whenever its ready (load) is high; an empty slot holds 0.
module gtech_pipe_stage
    import gtech_reduce_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Capture the upstream slot when ready; bubbles store zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= up_valid;
            data  <= up_valid ? up_data : '0;
        end
    end

endmodule

// File: rtl/gtech_reduce_pipe.sv
// gtech_reduce_pipe: N-operand, W-bit bitwise reduction (AND/OR/XOR/NAND/
// NOR/XNOR) followed by a STAGES-deep valid/ready register pipeline.
// Optional macro GTECH_REDUCE_STATUS_EN adds TXN_CNT and BUSY outputs.
module gtech_reduce_pipe
    import gtech_reduce_pkg::*;
#(
    parameter int N      = 3,
    parameter int W      = 1,
    parameter int STAGES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [MODE_W-1:0] MODE,
    input  logic [N*W-1:0]    DIN,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [W-1:0]      Z
`ifdef GTECH_REDUCE_STATUS_EN
    ,
    output logic [31:0]       TXN_CNT,
    output logic              BUSY
`endif
);

    if (N < 2 || W < 1 || STAGES < 1 || N > MAX_N || W > MAX_W) begin : g_param_check
        $fatal(1, "gtech_reduce_pipe: illegal parameters N=%0d W=%0d STAGES=%0d", N, W, STAGES);
    end

    logic [STAGES-1:0]        stage_valid;
    logic [STAGES-1:0][W-1:0] stage_data;
    logic [STAGES-1:0]        stage_ready;
    logic [MAX_VEC-1:0]       din_ext;
    logic [W-1:0]             reduced;

    // Zero-extend the operand bus to the width the shared function expects.
    always_comb begin
        din_ext          = '0;
        din_ext[N*W-1:0] = DIN;
    end

    assign reduced = W'(reduce(MODE, din_ext, N, W));

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic         up_valid;
        logic [W-1:0] up_data;

        if (k == 0) begin : g_head
            assign up_valid = IN_VALID;
            assign up_data  = reduced;
        end else begin : g_body
            assign up_valid = stage_valid[k-1];
            assign up_data  = stage_data[k-1];
        end

        // ready_k = ~valid_k | ready_(k+1) unrolled: stage k can move unless it
        // and every stage downstream of it are full and the sink is stalled.
        // Written flat so ready has no self-referencing combinational chain.
        assign stage_ready[k] = OUT_READY | ~(&stage_valid[STAGES-1:k]);

        gtech_pipe_stage #(.WIDTH(W)) u_stage (
            .clk      (CLK),
            .rst      (RST),
            .load     (stage_ready[k]),
            .up_valid (up_valid),
            .up_data  (up_data),
            .valid    (stage_valid[k]),
            .data     (stage_data[k])
        );
    end

    assign IN_READY  = stage_ready[0];
    assign OUT_VALID = stage_valid[STAGES-1];
    assign Z         = stage_data[STAGES-1];

`ifdef GTECH_REDUCE_STATUS_EN
    // Count completed output handshakes; wraps naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            TXN_CNT <= '0;
        end else if (OUT_VALID && OUT_READY) begin
            TXN_CNT <= TXN_CNT + 32'd1;
        end
    end

    assign BUSY = |stage_valid;
`endif

endmodule

// File: tb/tb_gtech_reduce_pipe.sv
// tb_gtech_reduce_pipe: self-checking bench for gtech_reduce_pipe.
// DUT A: N=3, W=1, STAGES=2 (NOR3 successor). DUT B: N=4, W=8, STAGES=3.
module tb_gtech_reduce_pipe;

    localparam int A_ST = 2;
    localparam int B_ST = 3;

    typedef struct {
        logic [2:0]  mode;
        logic [31:0] din;
        logic [7:0]  z;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [2:0]  a_mode;
    logic [2:0]  a_din;
    logic [0:0]  a_z;

    logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [2:0]  b_mode;
    logic [31:0] b_din;
    logic [7:0]  b_z;

`ifdef GTECH_REDUCE_STATUS_EN
    logic [31:0] a_txn_cnt, b_txn_cnt;
    logic        a_busy, b_busy;
`endif

    int check_cnt;
    int pass_cnt;

    gtech_reduce_pipe #(.N(3), .W(1), .STAGES(A_ST)) dut_a (
        .CLK       (clk),
        .RST       (a_rst),
        .IN_VALID  (a_in_valid),
        .IN_READY  (a_in_ready),
        .MODE      (a_mode),
        .DIN       (a_din),
        .OUT_VALID (a_out_valid),
        .OUT_READY (a_out_ready),
        .Z         (a_z)
`ifdef GTECH_REDUCE_STATUS_EN
        ,
        .TXN_CNT   (a_txn_cnt),
        .BUSY      (a_busy)
`endif
    );

    gtech_reduce_pipe #(.N(4), .W(8), .STAGES(B_ST)) dut_b (
        .CLK       (clk),
        .RST       (b_rst),
        .IN_VALID  (b_in_valid),
        .IN_READY  (b_in_ready),
        .MODE      (b_mode),
        .DIN       (b_din),
        .OUT_VALID (b_out_valid),
        .OUT_READY (b_out_ready),
        .Z         (b_z)
`ifdef GTECH_REDUCE_STATUS_EN
        ,
        .TXN_CNT   (b_txn_cnt),
        .BUSY      (b_busy)
`endif
    );

    // Reference: count ones in each bit column and apply the mode's rule.
    function automatic logic [7:0] refReduce(input logic [2:0] mode, input logic [31:0] din,
                                             input int n, input int w);
        logic [7:0] r;
        int ones;
        r = '0;
        for (int j = 0; j < w; j++) begin
            ones = 0;
            for (int i = 0; i < n; i++) ones += int'(din[i*w+j]);
            case (mode)
                3'd0:    r[j] = (ones == n);
                3'd1:    r[j] = (ones > 0);
                3'd2:    r[j] = (ones % 2 == 1);
                3'd3:    r[j] = (ones != n);
                3'd5:    r[j] = (ones % 2 == 0);
                default: r[j] = (ones == 0);
            endcase
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input bit to_a, input logic iv, input logic [2:0] mode,
                                 input logic [31:0] din, input logic ordy);
        if (to_a) begin
            a_in_valid  = iv;
            a_mode      = mode;
            a_din       = din[2:0];
            a_out_ready = ordy;
        end else begin
            b_in_valid  = iv;
            b_mode      = mode;
            b_din       = din;
            b_out_ready = ordy;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[7];
        logic [7:0]  exp_q[$];
        logic [7:0]  exp_z;
        logic [7:0]  hold_z;
        logic        hold_valid;
        logic [2:0]  mode;
        logic [31:0] din;
        logic        iv, ordy;
        int          accepts;

        // DIN = {op3,op2,op1,op0} = {F0,CC,AA,FF}; parity over all four
        // operands (FF included) is 8'h69, its complement 8'h96.
        vecs[0] = '{3'd0, 32'hF0CCAAFF, 8'h80};
        vecs[1] = '{3'd1, 32'hF0CCAAFF, 8'hFF};
        vecs[2] = '{3'd2, 32'hF0CCAAFF, 8'h69};
        vecs[3] = '{3'd3, 32'hF0CCAAFF, 8'h7F};
        vecs[4] = '{3'd4, 32'hF0CCAAFF, 8'h00};
        vecs[5] = '{3'd5, 32'hF0CCAAFF, 8'h96};
        vecs[6] = '{3'd7, 32'hF0CCAAFF, 8'h00};

        check_cnt = 0;
        pass_cnt  = 0;
        a_rst = 1'b1;
        b_rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("a_rst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("a_rst_z", 32'(a_z), 32'd0);
        checkOutput("a_rst_in_ready", 32'(a_in_ready), 32'd1);
        checkOutput("b_rst_out_valid", 32'(b_out_valid), 32'd0);
        checkOutput("b_rst_z", 32'(b_z), 32'd0);
        nextCycle();

        // Test 1: two items in flight, then reset discards them
        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 1'b1, 3'd4, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("t1_accept0", 32'(a_in_ready), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("t1_accept1", 32'(a_in_ready), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 3'd4, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("t1_full_in_ready", 32'(a_in_ready), 32'd0);
        checkOutput("t1_full_out_valid", 32'(a_out_valid), 32'd1);
        checkOutput("t1_full_z", 32'(a_z), 32'd1);
        nextCycle();
        a_rst = 1'b1;
        nextCycle();
        a_rst = 1'b0;
        @(negedge clk);
        checkOutput("t1_post_rst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("t1_post_rst_z", 32'(a_z), 32'd0);
        checkOutput("t1_post_rst_in_ready", 32'(a_in_ready), 32'd1);
        applyStimulus(1'b1, 1'b0, 3'd4, 32'd0, 1'b1);
        for (int t = 0; t < 4; t++) begin
            nextCycle();
            @(negedge clk);
            checkOutput("t1_no_ghost", 32'(a_out_valid), 32'd0);
        end
        nextCycle();

        // Test 2: exhaustive NOR3, result STAGES cycles after accept
        $display("[TB] exhaustive NOR3");
        for (int t = 0; t < 8 + A_ST; t++) begin
            if (t < 8) applyStimulus(1'b1, 1'b1, 3'd4, 32'(t), 1'b1);
            else       applyStimulus(1'b1, 1'b0, 3'd4, 32'd0, 1'b1);
            @(negedge clk);
            if (t < A_ST) begin
                checkOutput("t2_not_early", 32'(a_out_valid), 32'd0);
            end else begin
                checkOutput("t2_valid", 32'(a_out_valid), 32'd1);
                checkOutput("t2_z", 32'(a_z), (t == A_ST) ? 32'd1 : 32'd0);
            end
            nextCycle();
        end
        @(negedge clk);
        checkOutput("t2_drained", 32'(a_out_valid), 32'd0);
`ifdef GTECH_REDUCE_STATUS_EN
        checkOutput("t2_a_txn_cnt", a_txn_cnt, 32'd8);
        checkOutput("t2_a_busy", 32'(a_busy), 32'd0);
`endif
        nextCycle();

        // Test 3: all modes on a fixed 4x8 operand set
        $display("[TB] all modes");
        for (int t = 0; t < 7 + B_ST; t++) begin
            if (t < 7) applyStimulus(1'b0, 1'b1, vecs[t].mode, vecs[t].din, 1'b1);
            else       applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
            @(negedge clk);
            if (t >= B_ST) begin
                checkOutput("t3_valid", 32'(b_out_valid), 32'd1);
                checkOutput($sformatf("t3_z_mode%0d", vecs[t-B_ST].mode), 32'(b_z), 32'(vecs[t-B_ST].z));
            end
            nextCycle();
        end

        // Test 4: back-pressure fills exactly STAGES entries, then drains in order
        $display("[TB] back-pressure");
        accepts = 0;
        for (int t = 0; t < 6; t++) begin
            din = 32'(t + 1);
            applyStimulus(1'b0, 1'b1, 3'd2, din, 1'b0);
            @(negedge clk);
            if (b_in_ready) begin
                accepts++;
                exp_q.push_back(refReduce(3'd2, din, 4, 8));
            end
            nextCycle();
        end
        checkOutput("t4_accepts", 32'(accepts), 32'd3);
        @(negedge clk);
        checkOutput("t4_full_in_ready", 32'(b_in_ready), 32'd0);
        checkOutput("t4_stall_valid", 32'(b_out_valid), 32'd1);
        checkOutput("t4_stall_z", 32'(b_z), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            exp_z = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checkOutput("t4_drain_valid", 32'(b_out_valid), 32'd1);
            checkOutput("t4_drain_z", 32'(b_z), 32'(exp_z));
            nextCycle();
        end
        @(negedge clk);
        checkOutput("t4_empty", 32'(b_out_valid), 32'd0);
        nextCycle();

        // Test 5: random valid/ready against the queue model
        $display("[TB] random traffic");
        exp_q.delete();
        hold_valid = 1'b0;
        hold_z     = '0;
        for (int t = 0; t < 10000; t++) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            mode = 3'($urandom_range(0, 7));
            din  = $urandom;
            applyStimulus(1'b0, iv, mode, din, ordy);
            @(negedge clk);
            if (hold_valid) begin
                checkOutput("t5_stall_valid", 32'(b_out_valid), 32'd1);
                checkOutput("t5_stall_z", 32'(b_z), 32'(hold_z));
            end
            if (b_out_valid && b_out_ready) begin
                exp_z = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checkOutput("t5_z", 32'(b_z), 32'(exp_z));
            end
            if (b_in_valid && b_in_ready) exp_q.push_back(refReduce(mode, din, 4, 8));
            hold_valid = b_out_valid && !b_out_ready;
            hold_z     = b_z;
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        for (int t = 0; t < B_ST + 2; t++) begin
            @(negedge clk);
            if (b_out_valid) begin
                exp_z = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checkOutput("t5_drain_z", 32'(b_z), 32'(exp_z));
            end
            nextCycle();
        end
        checkOutput("t5_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef GTECH_REDUCE_STATUS_EN
        // Test 6: transfer counter and busy flag
        $display("[TB] status outputs");
        b_rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        nextCycle();
        b_rst = 1'b0;
        @(negedge clk);
        checkOutput("t6_cnt_reset", b_txn_cnt, 32'd0);
        checkOutput("t6_busy_idle", 32'(b_busy), 32'd0);
        nextCycle();
        for (int t = 0; t < 5; t++) begin
            applyStimulus(1'b0, 1'b1, 3'd0, 32'(t), 1'b1);
            @(negedge clk);
            if (t > 0) checkOutput("t6_busy_fill", 32'(b_busy), 32'd1);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        for (int t = 0; t < B_ST; t++) begin
            @(negedge clk);
            checkOutput("t6_busy_drain", 32'(b_busy), 32'd1);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("t6_cnt_final", b_txn_cnt, 32'd5);
        checkOutput("t6_busy_done", 32'(b_busy), 32'd0);
        nextCycle();
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
